// File: rtl/ap_accum.sv
// ap_accum: accumulates N signed terms per vector with per-step saturation and a sticky clamp flag.
module ap_accum #(
  parameter int WIDTH = 16,
  parameter int N     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_sat
);
  localparam int CW = $clog2(N + 1);
  localparam logic signed [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic {ACC, HOLD} state_t;
  state_t                  state;
  logic signed [WIDTH-1:0] acc, raw, sum;
  logic [CW-1:0]           cnt;
  logic                    sticky, pos_ov, neg_ov, clamp;
  always_comb begin
    raw    = acc + in_data;
    pos_ov = !acc[WIDTH-1] && !in_data[WIDTH-1] && raw[WIDTH-1];
    neg_ov = acc[WIDTH-1] && in_data[WIDTH-1] && !raw[WIDTH-1];
    clamp  = pos_ov || neg_ov;
    sum    = pos_ov ? MAX : neg_ov ? MIN : raw;
  end
  // in_ready is registered so it stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else if (state == ACC) begin
      in_ready <= 1'b1;
      if (in_valid && in_ready) begin
        if (cnt == CW'(N - 1)) begin
          out_data  <= sum;
          out_sat   <= sticky || clamp;
          out_valid <= 1'b1;
          in_ready  <= 1'b0;
          state     <= HOLD;
          acc       <= '0;
          cnt       <= '0;
          sticky    <= 1'b0;
        end else begin
          acc    <= sum;
          cnt    <= cnt + CW'(1);
          sticky <= sticky || clamp;
        end
      end
    end else if (out_ready) begin
      state     <= ACC;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ap_accum.sv
// tb_ap_accum: directed and randomized checks of ap_accum at WIDTH=8, N=4.
module tb_ap_accum;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [7:0] out_data;
  logic              out_sat;
  int                n_checks = 0;
  int                n_fail = 0;

  ap_accum #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp8(input int s);
    return s > 127 ? 127 : (s < -128 ? -128 : s);
  endfunction

  task automatic send(input int x);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'(x);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", t, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  // expects out_valid at the first negedge after the last accept; out_ready must be 1
  task automatic recv(input string tag, input int ed, input int es);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_latency"}, t, 0);
    check({tag, "_data"}, int'(out_data), ed);
    check({tag, "_sat"}, int'(out_sat), es);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, int'(out_valid), 0);
    check({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    int macc, mcnt, vecs, cyc, d, s;
    bit msat;
    int qd[$];
    bit qs[$];
    #2;
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_release", int'(in_ready), 1);

    send(10); send(20); send(-5);
    check("v1_no_early_valid", int'(out_valid), 0);
    send(3);
    recv("v1", 28, 0);

    send4(100, 100, -50, 0);
    recv("v2", 77, 1);
    send4(-100, -100, -128, 5);
    recv("v3", -123, 1);
    send4(1, 1, 1, 1);
    recv("v4", 4, 0);

    out_ready = 1'b0;
    send4(127, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'sd55;
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", int'(out_data), 127);
      check("hold_sat", int'(out_sat), 1);
      check("hold_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("hold_release", int'(out_valid), 0);
    send4(2, 2, 2, 2);
    recv("v6", 8, 0);

    send(50); send(50);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", int'(out_data), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_ready", int'(in_ready), 0);
    @(negedge clk);
    check("mid_rst_ready_held", int'(in_ready), 0);
    rst_n = 1'b1;
    send4(1, 2, 3, 4);
    recv("v7", 10, 0);

    macc = 0; mcnt = 0; msat = 1'b0; vecs = 0; cyc = 0;
    while (vecs < 1000 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      in_valid  = ($urandom_range(0, 9) < 7);
      d         = int'($urandom_range(0, 255)) - 128;
      in_data   = 8'(d);
      out_ready = $urandom_range(0, 1) == 1;
      if (out_valid && out_ready) begin
        if (qd.size() == 0) check("rnd_unexpected_out", 1, 0);
        else begin
          check("rnd_data", int'(out_data), qd.pop_front());
          check("rnd_sat", int'(out_sat), int'(qs.pop_front()));
        end
        vecs++;
      end
      if (in_valid && in_ready) begin
        s    = macc + d;
        msat = msat | (s != clamp8(s));
        macc = clamp8(s);
        mcnt++;
        if (mcnt == 4) begin
          qd.push_back(macc);
          qs.push_back(msat);
          macc = 0; mcnt = 0; msat = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    check("rnd_vectors_done", vecs, 1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
